cam_pix_packer: RTL and testbench

Parametrised camera pixel packer between the DVP capture path and the video DMA. It accepts one-pixel-per-beat grey data already synchronised to `sys_clock`. Each frame it either passes the pixels through or binarises them against a threshold, which generalises the fixed `bin_enable`/`threshold` path. It packs the result into `OUT_W`-bit stream words, buffers them in a small FIFO, and drops whole frame remainders on overflow instead of corrupting the stream.

---
 rtl/cam_pkg.sv | 21 ++
 rtl/cam_pix_packer_if.sv | 13 +
 rtl/cam_stream_fifo.sv | 49 ++++
 rtl/cam_pix_packer.sv | 139 +++++++++++++
 tb/tb_cam_pix_packer.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cam_pkg.sv
// Shared encodings and helpers for the camera pixel packer.
package cam_pkg;

    localparam logic [1:0] MODE_GREY    = 2'b00;
    localparam logic [1:0] MODE_BIN     = 2'b01;
    localparam logic [1:0] MODE_BIN_INV = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACTIVE,
        ST_DROP
    } cam_state_t;

    // Binary modes pack one bit per pixel; everything else packs whole pixels.
    function automatic int pix_per_word(input logic [1:0] mode, input int out_w, input int pix_w);
        if (mode == MODE_BIN || mode == MODE_BIN_INV)
            return out_w;
        return out_w / pix_w;
    endfunction

endpackage

// File: rtl/cam_pix_packer_if.sv
// Output word stream between the packer and the video DMA.
interface cam_pix_packer_if #(
    parameter int OUT_W = 32
);
    logic             tvalid;
    logic             tready;
    logic [OUT_W-1:0] tdata;
    logic             tuser;
    logic             tlast;

    modport master (output tvalid, tdata, tuser, tlast, input tready);
    modport slave  (input tvalid, tdata, tuser, tlast, output tready);
endinterface

// File: rtl/cam_stream_fifo.sv
// Show-ahead synchronous FIFO; a read in the same cycle frees a slot for a write when full.
module cam_stream_fifo #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 16
) (
    input  logic             sys_clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_rd   = rd_en && !empty;
    assign do_wr   = wr_en && (!full || do_rd);
    // Output forced to zero when empty so the stream never shows stale or unknown data.
    assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge sys_clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge sys_clock) begin
        if (do_wr && !clear)
            mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/cam_pix_packer.sv
// Grey/binary pixel packer with frame-level overflow dropping and a buffered output stream.
//   state     | meaning
//   ST_IDLE   | waiting for an enabled SOF
//   ST_ACTIVE | packing pixels into words
//   ST_DROP   | word lost on full FIFO; ignoring pixels until next SOF
module cam_pix_packer
    import cam_pkg::*;
#(
    parameter int PIX_W      = 8,
    parameter int OUT_W      = 32,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = 16
) (
    input  logic              sys_clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              clear,
    input  logic [1:0]        mode,
    input  logic [PIX_W-1:0]  threshold,
    input  logic              pix_valid,
    input  logic [PIX_W-1:0]  pix_data,
    input  logic              pix_sof,
    input  logic              pix_eol,
    cam_pix_packer_if.master  m,
    output logic [CNT_W-1:0]  frame_cnt,
    output logic [CNT_W-1:0]  ovf_cnt,
    output logic              busy
);
    localparam int IDX_W = $clog2(OUT_W);

    cam_state_t       state_q, state_d;
    logic [1:0]       mode_q, mode_eff;
    logic [PIX_W-1:0] thr_q, thr_eff;
    logic [OUT_W-1:0] word_q, word_nx, base_word;
    logic [IDX_W-1:0] idx_q, base_idx;
    logic             user_q, base_user;
    logic             start, take, complete, can_accept, push, ovf_hit, bin_mode, bin_bit;
    logic             fifo_full, fifo_empty;
    logic [OUT_W+1:0] fifo_rd;

    always_comb begin
        start     = pix_valid && pix_sof && enable;
        take      = start || (pix_valid && !pix_sof && state_q == ST_ACTIVE);
        mode_eff  = start ? mode : mode_q;
        thr_eff   = start ? threshold : thr_q;
        bin_mode  = (mode_eff == MODE_BIN) || (mode_eff == MODE_BIN_INV);
        bin_bit   = (mode_eff == MODE_BIN) ? (pix_data >= thr_eff) : (pix_data < thr_eff);
        // An SOF beat always opens a fresh word, discarding any partial one.
        base_word = start ? '0 : word_q;
        base_idx  = start ? '0 : idx_q;
        base_user = start ? 1'b1 : user_q;
        word_nx   = base_word;
        if (bin_mode)
            word_nx[base_idx] = bin_bit;
        else
            word_nx[int'(base_idx)*PIX_W +: PIX_W] = pix_data;
        complete   = take && (pix_eol ||
                     (int'(base_idx) == pix_per_word(mode_eff, OUT_W, PIX_W) - 1));
        can_accept = !fifo_full || (m.tvalid && m.tready);
        push       = complete && can_accept && !clear;
        ovf_hit    = complete && !can_accept;

        state_d = state_q;
        if (pix_valid && pix_sof)
            state_d = enable ? ST_ACTIVE : ST_IDLE;
        if (ovf_hit)
            state_d = ST_DROP;
        if (clear)
            state_d = ST_IDLE;
    end

    always_ff @(posedge sys_clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            busy    <= (state_d != ST_IDLE);
        end
    end

    always_ff @(posedge sys_clock or negedge reset) begin
        if (!reset) begin
            mode_q    <= MODE_GREY;
            thr_q     <= '0;
            word_q    <= '0;
            idx_q     <= '0;
            user_q    <= 1'b0;
            frame_cnt <= '0;
            ovf_cnt   <= '0;
        end else if (clear) begin
            word_q    <= '0;
            idx_q     <= '0;
            user_q    <= 1'b0;
            frame_cnt <= '0;
            ovf_cnt   <= '0;
        end else begin
            if (start) begin
                mode_q    <= mode;
                thr_q     <= threshold;
                frame_cnt <= frame_cnt + 1'b1;
            end
            if (take) begin
                if (complete) begin
                    word_q <= '0;
                    idx_q  <= '0;
                    user_q <= 1'b0;
                end else begin
                    word_q <= word_nx;
                    idx_q  <= base_idx + 1'b1;
                    user_q <= base_user;
                end
            end
            if (ovf_hit && ovf_cnt != '1)
                ovf_cnt <= ovf_cnt + 1'b1;
        end
    end

    cam_stream_fifo #(
        .WIDTH (OUT_W + 2),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .sys_clock (sys_clock),
        .reset     (reset),
        .clear     (clear),
        .wr_en     (push),
        .wr_data   ({base_user, pix_eol, word_nx}),
        .rd_en     (m.tready),
        .rd_data   (fifo_rd),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign m.tvalid = !fifo_empty;
    assign m.tuser  = fifo_rd[OUT_W+1];
    assign m.tlast  = fifo_rd[OUT_W];
    assign m.tdata  = fifo_rd[OUT_W-1:0];

endmodule

// File: tb/tb_cam_pix_packer.sv
// Scoreboard bench for cam_pix_packer: directed frames plus randomized traffic against a word-level model.
module tb_cam_pix_packer;
    localparam int PIX_W = 8;
    localparam int OUT_W = 32;
    localparam int DEPTH = 4;
    localparam int CNT_W = 16;

    logic             sys_clock = 1'b0;
    logic             reset = 1'b0;
    logic             enable = 1'b0;
    logic             clear = 1'b0;
    logic [1:0]       mode = 2'b00;
    logic [PIX_W-1:0] threshold = '0;
    logic             pix_valid = 1'b0;
    logic [PIX_W-1:0] pix_data = '0;
    logic             pix_sof = 1'b0;
    logic             pix_eol = 1'b0;
    logic [CNT_W-1:0] frame_cnt, ovf_cnt;
    logic             busy;

    cam_pix_packer_if #(.OUT_W(OUT_W)) bus ();

    cam_pix_packer #(
        .PIX_W(PIX_W), .OUT_W(OUT_W), .FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)
    ) dut (
        .sys_clock (sys_clock),
        .reset     (reset),
        .enable    (enable),
        .clear     (clear),
        .mode      (mode),
        .threshold (threshold),
        .pix_valid (pix_valid),
        .pix_data  (pix_data),
        .pix_sof   (pix_sof),
        .pix_eol   (pix_eol),
        .m         (bus),
        .frame_cnt (frame_cnt),
        .ovf_cnt   (ovf_cnt),
        .busy      (busy)
    );

    always #5 sys_clock = ~sys_clock;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: words waiting in the output buffer, pixels of the word being built.
    logic [OUT_W+1:0] sb[$];
    logic [OUT_W+1:0] got_log[$];
    int unsigned      cur[$];
    int               occ = 0;
    bit               cap = 0;
    bit               busy_m = 0;
    bit               user_p = 0;
    logic [1:0]       mode_l = 2'b00;
    logic [PIX_W-1:0] thr_l = '0;
    logic [CNT_W-1:0] frame_m = '0;
    logic [CNT_W-1:0] ovf_m = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 30)
                $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        sb.delete();
        cur.delete();
        occ = 0; cap = 0; busy_m = 0; user_p = 0;
        frame_m = '0; ovf_m = '0;
    endtask

    function automatic bit is_bin(input logic [1:0] md);
        return (md == 2'b01) || (md == 2'b10);
    endfunction

    task automatic model_edge();
        bit rd, take;
        int ppw, bits;
        int unsigned v;
        logic [OUT_W-1:0] w;
        if (!reset) return;
        rd = bus.tready && (occ != 0);
        if (clear) begin
            model_clear();
            return;
        end
        take = 0;
        if (pix_valid && pix_sof) begin
            if (enable) begin
                cap = 1; busy_m = 1; take = 1;
                mode_l = mode; thr_l = threshold;
                frame_m = frame_m + 1'b1;
                cur.delete();
                user_p = 1;
            end else begin
                cap = 0; busy_m = 0;
            end
        end else begin
            take = pix_valid && cap;
        end
        if (take) begin
            ppw  = is_bin(mode_l) ? OUT_W : OUT_W / PIX_W;
            bits = is_bin(mode_l) ? 1 : PIX_W;
            if (mode_l == 2'b01)      v = (pix_data >= thr_l) ? 1 : 0;
            else if (mode_l == 2'b10) v = (pix_data <  thr_l) ? 1 : 0;
            else                      v = pix_data;
            cur.push_back(v);
            if (cur.size() == ppw || pix_eol) begin
                w = '0;
                for (int i = 0; i < cur.size(); i++)
                    w = w | (OUT_W'(cur[i]) << (bits * i));
                if (occ < DEPTH || rd) begin
                    sb.push_back({user_p, pix_eol, w});
                    occ++;
                end else begin
                    if (ovf_m != '1) ovf_m = ovf_m + 1'b1;
                    cap = 0;
                end
                cur.delete();
                user_p = 0;
            end
        end
        if (rd) occ--;
    endtask

    task automatic tick();
        @(posedge sys_clock);
        model_edge();
        #1;
    endtask

    task automatic beat(input logic [PIX_W-1:0] d, input bit s, input bit e);
        pix_valid = 1'b1; pix_data = d; pix_sof = s; pix_eol = e;
        tick();
        pix_valid = 1'b0; pix_sof = 1'b0; pix_eol = 1'b0;
    endtask

    task automatic idle(input int n);
        pix_valid = 1'b0; pix_sof = 1'b0; pix_eol = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic drain(input int budget);
        int k;
        bus.tready = 1'b1;
        k = 0;
        while (occ != 0 && k < budget) begin
            idle(1);
            k++;
        end
        check("drain_timeout", 64'(occ), 64'd0);
    endtask

    // Monitor: cycle-level status against the model, word-level data against the scoreboard.
    always @(negedge sys_clock) begin
        logic [OUT_W+1:0] exp_w;
        check("tvalid", 64'(bus.tvalid), 64'(occ != 0));
        check("busy", 64'(busy), 64'(busy_m));
        check("frame_cnt", 64'(frame_cnt), 64'(frame_m));
        check("ovf_cnt", 64'(ovf_cnt), 64'(ovf_m));
        if (bus.tvalid && bus.tready) begin
            got_log.push_back({bus.tuser, bus.tlast, bus.tdata});
            if (sb.size() == 0) begin
                check("unexpected_word", {30'd0, bus.tuser, bus.tlast, bus.tdata}, 64'd0);
            end else begin
                exp_w = sb.pop_front();
                check("word", 64'({bus.tuser, bus.tlast, bus.tdata}), 64'(exp_w));
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.tready = 1'b1;
        idle(2);
        reset = 1'b1;
        idle(1);
        check("rst_tvalid", 64'(bus.tvalid), 64'd0);
        check("rst_tdata", 64'(bus.tdata), 64'd0);
        check("rst_tuser", 64'(bus.tuser), 64'd0);
        check("rst_tlast", 64'(bus.tlast), 64'd0);
        check("rst_frame", 64'(frame_cnt), 64'd0);
        check("rst_ovf", 64'(ovf_cnt), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);

        // Grey line of 8 pixels
        enable = 1'b1; mode = 2'b00;
        got_log.delete();
        for (int i = 1; i <= 8; i++) beat(8'(i), i == 1, i == 8);
        idle(3);
        check("grey_cnt", 64'(got_log.size()), 64'd2);
        check("grey_w0", 64'(got_log[0]), {30'd0, 2'b10, 32'h04030201});
        check("grey_w1", 64'(got_log[1]), {30'd0, 2'b01, 32'h08070605});
        check("grey_frame", 64'(frame_cnt), 64'd1);

        // Binary and inverted binary, 32 alternating pixels
        threshold = 8'h80;
        for (int pass = 0; pass < 2; pass++) begin
            mode = (pass == 0) ? 2'b01 : 2'b10;
            got_log.delete();
            for (int i = 0; i < 32; i++) beat((i % 2) ? 8'h80 : 8'h7F, i == 0, i == 31);
            idle(3);
            check("bin_cnt", 64'(got_log.size()), 64'd1);
            check("bin_word", 64'(got_log[0]),
                  {30'd0, 2'b11, (pass == 0) ? 32'hAAAAAAAA : 32'h55555555});
        end

        // Short line with zero-padded tail
        mode = 2'b00;
        got_log.delete();
        for (int i = 0; i < 5; i++) beat(8'h11 + 8'(i), i == 0, i == 4);
        idle(3);
        check("short_w0", 64'(got_log[0]), {30'd0, 2'b10, 32'h14131211});
        check("short_w1", 64'(got_log[1]), {30'd0, 2'b01, 32'h00000015});

        // Single pixel carrying SOF and EOL
        got_log.delete();
        beat(8'hAB, 1, 1);
        idle(3);
        check("single", 64'(got_log[0]), {30'd0, 2'b11, 32'h000000AB});

        // Overflow with stalled sink
        bus.tready = 1'b0;
        got_log.delete();
        for (int i = 0; i < 24; i++) beat(8'(i), i == 0, i == 23);
        idle(2);
        check("ovf_nowords", 64'(got_log.size()), 64'd0);
        check("ovf_valid", 64'(bus.tvalid), 64'd1);
        check("ovf_count", 64'(ovf_cnt), 64'd1);
        check("ovf_busy", 64'(busy), 64'd1);
        drain(20);
        check("ovf_drained", 64'(got_log.size()), 64'd4);
        got_log.delete();
        for (int i = 0; i < 4; i++) beat(8'h21 + 8'(i), i == 0, i == 3);
        idle(3);
        check("resume_word", 64'(got_log[0]), {30'd0, 2'b11, 32'h24232221});

        // Soft clear with buffered words, then SOF while disabled
        bus.tready = 1'b0;
        got_log.delete();
        for (int i = 0; i < 12; i++) beat(8'(i), i == 0, 0);
        check("clr_pre_valid", 64'(bus.tvalid), 64'd1);
        clear = 1'b1;
        idle(1);
        clear = 1'b0;
        check("clr_valid", 64'(bus.tvalid), 64'd0);
        check("clr_frame", 64'(frame_cnt), 64'd0);
        check("clr_ovf", 64'(ovf_cnt), 64'd0);
        check("clr_busy", 64'(busy), 64'd0);
        enable = 1'b0;
        beat(8'h55, 1, 1);
        bus.tready = 1'b1;
        idle(4);
        check("dis_words", 64'(got_log.size()), 64'd0);
        check("dis_frame", 64'(frame_cnt), 64'd0);

        // Randomized traffic with one asynchronous reset mid-run
        for (int c = 0; c < 4000; c++) begin
            if (c == 2000) begin
                reset = 1'b0;
                model_clear();
                tick();
                reset = 1'b1;
            end
            pix_valid  = ($urandom_range(3) != 0);
            pix_sof    = pix_valid && ($urandom_range(39) == 0);
            pix_eol    = pix_valid && ($urandom_range(7) == 0);
            pix_data   = PIX_W'($urandom);
            mode       = 2'($urandom);
            threshold  = PIX_W'($urandom);
            enable     = ($urandom_range(9) != 0);
            clear      = ($urandom_range(599) == 0);
            bus.tready = ($urandom_range(9) < 7);
            tick();
        end
        clear = 1'b0;
        idle(1);
        drain(50);
        check("final_sb_empty", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
